// File: rtl/zero_pad_block_if.sv
// AXI-Stream style handshake bundle shared by the sample source, the
// zero-pad block and the FFT input.
interface AXIS_intf #(
  parameter int DW = 16
) ();
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;

  modport Master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport Slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/zero_pad_block.sv
// Input-side framing for the fast correlator: forwards the first N samples
// of a frame unchanged, then appends zeros until exactly NFFT beats have
// left the block.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; both stream sides idle, counter held at 0
// PASS  | combinational pass-through of the first n_reg input samples
// PAD   | upstream held off, zero beats emitted up to beat NFFT-1
module zero_pad_block #(
  parameter int NFFT = 256
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [12:0] N,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        out_last,
  AXIS_intf.Slave     indata,
  AXIS_intf.Master    outdata
);

  // 14-bit arithmetic so NFFT=8192 and its last index fit without wrapping.
  localparam logic [13:0] NFFT_W    = 14'(NFFT);
  localparam logic [13:0] LAST_BEAT = 14'(NFFT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    PAD  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [13:0] counter;
  logic [13:0] counter_nxt;
  logic [13:0] n_reg;
  logic [13:0] n_reg_nxt;
  logic [13:0] n_ext;
  logic [13:0] n_clamp;
  logic        out_valid;
  logic        in_ready;
  logic        fire;

  assign n_ext   = {1'b0, N};
  assign n_clamp = (n_ext > NFFT_W) ? NFFT_W : n_ext;

  assign fire     = out_valid & outdata.tready;
  assign busy     = (state != IDLE);
  assign out_last = busy & (counter == LAST_BEAT);
  assign done     = fire & out_last;

  assign outdata.tvalid = out_valid;
  assign indata.tready  = in_ready;

  // Stream steering: pass-through in PASS, zero source in PAD, quiet in IDLE.
  always_comb begin
    out_valid     = 1'b0;
    in_ready      = 1'b0;
    outdata.tdata = '0;
    case (state)
      PASS: begin
        out_valid     = indata.tvalid;
        in_ready      = outdata.tready;
        outdata.tdata = indata.tdata;
      end
      PAD: begin
        out_valid = 1'b1;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

  // Next-state, beat counter and frame length capture.
  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    n_reg_nxt   = n_reg;
    case (state)
      IDLE: begin
        counter_nxt = '0;
        if (start) begin
          n_reg_nxt = n_clamp;
          state_nxt = (n_clamp != 14'd0) ? PASS : PAD;
        end
      end
      PASS: begin
        if (fire) begin
          counter_nxt = counter + 14'd1;
          if (counter == (n_reg - 14'd1)) begin
            // A full-length frame has no tail: the last sample is the last beat.
            if (n_reg == NFFT_W) begin
              state_nxt   = IDLE;
              counter_nxt = '0;
            end else begin
              state_nxt = PAD;
            end
          end
        end
      end
      PAD: begin
        if (fire) begin
          if (counter == LAST_BEAT) begin
            state_nxt   = IDLE;
            counter_nxt = '0;
          end else begin
            counter_nxt = counter + 14'd1;
          end
        end
      end
      default: begin
        state_nxt   = IDLE;
        counter_nxt = '0;
      end
    endcase
  end

  // State register with synchronous active-low reset; reset aborts a frame.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state   <= IDLE;
      counter <= '0;
      n_reg   <= '0;
    end else begin
      state   <= state_nxt;
      counter <= counter_nxt;
      n_reg   <= n_reg_nxt;
    end
  end

endmodule

// File: tb/tb_zero_pad_block.sv
// Self-checking bench for zero_pad_block with NFFT=16.
module tb_zero_pad_block;
  localparam int NFFT = 16;

  logic        aclk;
  logic        aresetn;
  logic [12:0] n_in;
  logic        start;
  logic        busy;
  logic        done;
  logic        out_last;

  AXIS_intf #(.DW(16)) in_if ();
  AXIS_intf #(.DW(16)) out_if ();

  zero_pad_block #(.NFFT(NFFT)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .N       (n_in),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .out_last(out_last),
    .indata  (in_if),
    .outdata (out_if)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] src[$];
  logic [15:0] obs[$];
  int consumed, done_cnt, done_beat, last_bad, pad_bad, in_ready_cnt, end_gap;
  bit timed_out;
  logic abort_tv, abort_busy, abort_done;

  // Drives one frame: random source gaps and sink stalls, optional stray
  // starts and an optional reset at a given beat. Records what came out.
  task automatic drive_frame(input int n, input int src_len, input int vprob,
                             input int rprob, input int mid_start_cyc,
                             input bit start_in_done, input int abort_beat,
                             input bit start_now);
    int nclamp;
    int cyc;
    int done_cyc;
    nclamp = (n > NFFT) ? NFFT : n;
    src.delete();
    obs.delete();
    for (int i = 0; i < src_len; i++) src.push_back(16'($urandom_range(1, 65535)));
    consumed = 0; done_cnt = 0; done_beat = -1; last_bad = 0; pad_bad = 0;
    in_ready_cnt = 0; end_gap = -1; timed_out = 0; done_cyc = -1;
    if (!start_now) @(negedge aclk);
    start = 1'b1;
    n_in  = 13'(n);
    @(posedge aclk);
    @(negedge aclk);
    n_in = 13'($urandom);
    cyc = 0;
    while (1) begin
      start = (cyc == mid_start_cyc);
      if (start) n_in = 13'($urandom);
      in_if.tvalid  = (consumed < src.size()) && ($urandom_range(0, 99) < vprob);
      in_if.tdata   = in_if.tvalid ? src[consumed] : 16'($urandom);
      out_if.tready = ($urandom_range(0, 99) < rprob);
      if (abort_beat >= 0 && obs.size() == abort_beat) begin
        out_if.tready = 1'b0;
        start = 1'b0;
        aresetn = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        #1;
        abort_tv   = out_if.tvalid;
        abort_busy = busy;
        abort_done = done;
        aresetn = 1'b1;
        break;
      end
      #1;
      if (busy !== 1'b1) begin
        end_gap = cyc - done_cyc;
        break;
      end
      if (out_last !== (obs.size() == NFFT - 1)) last_bad++;
      if (obs.size() >= nclamp &&
          (out_if.tvalid !== 1'b1 || out_if.tdata !== 16'd0 || in_if.tready !== 1'b0))
        pad_bad++;
      if (in_if.tready === 1'b1) in_ready_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        done_beat = obs.size();
        done_cyc  = cyc;
      end
      if (out_if.tvalid === 1'b1 && out_if.tready === 1'b1) obs.push_back(out_if.tdata);
      if (in_if.tvalid === 1'b1 && in_if.tready === 1'b1) consumed++;
      if (start_in_done && done === 1'b1) begin
        start = 1'b1;
        n_in  = 13'($urandom);
      end
      cyc++;
      if (cyc > 400) begin
        timed_out = 1;
        break;
      end
      @(negedge aclk);
    end
    start = 1'b0;
    in_if.tvalid = 1'b0;
    out_if.tready = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; start = 1'b0; n_in = '0;
    in_if.tvalid = 1'b0; in_if.tdata = '0; out_if.tready = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_last got=%b exp=0", out_last); end
    n_cmp++; if (out_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid got=%b exp=0", out_if.tvalid); end
    n_cmp++; if (in_if.tready !== 1'b0) begin n_bad++; $display("FAIL reset_tready got=%b exp=0", in_if.tready); end
    aresetn = 1'b1;
    out_if.tready = 1'b0;
    @(negedge aclk);
  endtask

  task automatic test_basic();
    logic [15:0] exp;
    drive_frame(5, 8, 100, 100, -1, 0, -1, 0);
    n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL basic_timeout got=%b exp=0", timed_out); end
    n_cmp++; if (obs.size() !== NFFT) begin n_bad++; $display("FAIL basic_beats got=%0d exp=%0d", obs.size(), NFFT); end
    for (int i = 0; i < NFFT && i < obs.size(); i++) begin
      exp = (i < 5) ? src[i] : 16'd0;
      n_cmp++; if (obs[i] !== exp) begin n_bad++; $display("FAIL basic_beat%0d got=%h exp=%h", i, obs[i], exp); end
    end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt); end
    n_cmp++; if (done_beat !== NFFT - 1) begin n_bad++; $display("FAIL basic_done_beat got=%0d exp=%0d", done_beat, NFFT - 1); end
    n_cmp++; if (last_bad !== 0) begin n_bad++; $display("FAIL basic_out_last got=%0d bad cycles exp=0", last_bad); end
    n_cmp++; if (consumed !== 5) begin n_bad++; $display("FAIL basic_consumed got=%0d exp=5", consumed); end
    n_cmp++; if (end_gap !== 1) begin n_bad++; $display("FAIL basic_busy_fall got=%0d exp=1", end_gap); end
    n_cmp++; if (pad_bad !== 0) begin n_bad++; $display("FAIL basic_pad got=%0d exp=0", pad_bad); end
  endtask

  task automatic test_zero_n();
    drive_frame(0, 4, 100, 100, -1, 0, -1, 0);
    n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL zero_timeout got=%b exp=0", timed_out); end
    n_cmp++; if (obs.size() !== NFFT) begin n_bad++; $display("FAIL zero_beats got=%0d exp=%0d", obs.size(), NFFT); end
    for (int i = 0; i < obs.size(); i++) begin
      n_cmp++; if (obs[i] !== 16'd0) begin n_bad++; $display("FAIL zero_beat%0d got=%h exp=0000", i, obs[i]); end
    end
    n_cmp++; if (in_ready_cnt !== 0) begin n_bad++; $display("FAIL zero_tready got=%0d exp=0", in_ready_cnt); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL zero_done_cnt got=%0d exp=1", done_cnt); end
    n_cmp++; if (done_beat !== NFFT - 1) begin n_bad++; $display("FAIL zero_done_beat got=%0d exp=%0d", done_beat, NFFT - 1); end
  endtask

  task automatic test_full();
    int lens[2] = '{16, 20};
    foreach (lens[k]) begin
      drive_frame(lens[k], NFFT + 1, 100, 100, -1, 0, -1, 0);
      n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL full_timeout n=%0d got=%b exp=0", lens[k], timed_out); end
      n_cmp++; if (obs.size() !== NFFT) begin n_bad++; $display("FAIL full_beats n=%0d got=%0d exp=%0d", lens[k], obs.size(), NFFT); end
      for (int i = 0; i < obs.size(); i++) begin
        n_cmp++; if (obs[i] !== src[i]) begin n_bad++; $display("FAIL full_beat%0d n=%0d got=%h exp=%h", i, lens[k], obs[i], src[i]); end
      end
      n_cmp++; if (consumed !== NFFT) begin n_bad++; $display("FAIL full_consumed n=%0d got=%0d exp=%0d", lens[k], consumed, NFFT); end
      n_cmp++; if (done_beat !== NFFT - 1) begin n_bad++; $display("FAIL full_done_beat n=%0d got=%0d exp=%0d", lens[k], done_beat, NFFT - 1); end
      n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL full_done_cnt n=%0d got=%0d exp=1", lens[k], done_cnt); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp;
    drive_frame(8, 10, 60, 50, -1, 0, -1, 0);
    n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL bp_timeout got=%b exp=0", timed_out); end
    n_cmp++; if (obs.size() !== NFFT) begin n_bad++; $display("FAIL bp_beats got=%0d exp=%0d", obs.size(), NFFT); end
    for (int i = 0; i < obs.size(); i++) begin
      exp = (i < 8) ? src[i] : 16'd0;
      n_cmp++; if (obs[i] !== exp) begin n_bad++; $display("FAIL bp_beat%0d got=%h exp=%h", i, obs[i], exp); end
    end
    n_cmp++; if (pad_bad !== 0) begin n_bad++; $display("FAIL bp_pad_stall got=%0d exp=0", pad_bad); end
    n_cmp++; if (last_bad !== 0) begin n_bad++; $display("FAIL bp_out_last got=%0d exp=0", last_bad); end
    n_cmp++; if (consumed !== 8) begin n_bad++; $display("FAIL bp_consumed got=%0d exp=8", consumed); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL bp_done_cnt got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_start_ignored();
    logic [15:0] exp;
    drive_frame(5, 8, 100, 100, 3, 1, -1, 0);
    n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL ign_timeout got=%b exp=0", timed_out); end
    n_cmp++; if (obs.size() !== NFFT) begin n_bad++; $display("FAIL ign_beats got=%0d exp=%0d", obs.size(), NFFT); end
    for (int i = 0; i < obs.size(); i++) begin
      exp = (i < 5) ? src[i] : 16'd0;
      n_cmp++; if (obs[i] !== exp) begin n_bad++; $display("FAIL ign_beat%0d got=%h exp=%h", i, obs[i], exp); end
    end
    n_cmp++; if (end_gap !== 1) begin n_bad++; $display("FAIL ign_done_start got=%0d exp=1", end_gap); end
    drive_frame(3, 6, 100, 100, -1, 0, -1, 1);
    n_cmp++; if (obs.size() !== NFFT) begin n_bad++; $display("FAIL b2b_beats got=%0d exp=%0d", obs.size(), NFFT); end
    for (int i = 0; i < obs.size(); i++) begin
      exp = (i < 3) ? src[i] : 16'd0;
      n_cmp++; if (obs[i] !== exp) begin n_bad++; $display("FAIL b2b_beat%0d got=%h exp=%h", i, obs[i], exp); end
    end
    n_cmp++; if (consumed !== 3) begin n_bad++; $display("FAIL b2b_consumed got=%0d exp=3", consumed); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp;
    drive_frame(4, 6, 100, 100, -1, 0, 10, 0);
    n_cmp++; if (obs.size() !== 10) begin n_bad++; $display("FAIL abort_beats got=%0d exp=10", obs.size()); end
    n_cmp++; if (abort_tv !== 1'b0) begin n_bad++; $display("FAIL abort_tvalid got=%b exp=0", abort_tv); end
    n_cmp++; if (abort_busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%b exp=0", abort_busy); end
    n_cmp++; if (abort_done !== 1'b0) begin n_bad++; $display("FAIL abort_done got=%b exp=0", abort_done); end
    n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL abort_done_cnt got=%0d exp=0", done_cnt); end
    drive_frame(7, 9, 100, 100, -1, 0, -1, 0);
    n_cmp++; if (obs.size() !== NFFT) begin n_bad++; $display("FAIL post_beats got=%0d exp=%0d", obs.size(), NFFT); end
    for (int i = 0; i < obs.size(); i++) begin
      exp = (i < 7) ? src[i] : 16'd0;
      n_cmp++; if (obs[i] !== exp) begin n_bad++; $display("FAIL post_beat%0d got=%h exp=%h", i, obs[i], exp); end
    end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL post_done_cnt got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_random();
    int n;
    int nclamp;
    logic [15:0] exp;
    for (int f = 0; f < 4; f++) begin
      n = $urandom_range(0, 20);
      nclamp = (n > NFFT) ? NFFT : n;
      drive_frame(n, nclamp + 2, 70, 70, -1, 0, -1, 0);
      n_cmp++; if (obs.size() !== NFFT) begin n_bad++; $display("FAIL rnd_beats n=%0d got=%0d exp=%0d", n, obs.size(), NFFT); end
      for (int i = 0; i < obs.size(); i++) begin
        exp = (i < nclamp) ? src[i] : 16'd0;
        n_cmp++; if (obs[i] !== exp) begin n_bad++; $display("FAIL rnd_beat%0d n=%0d got=%h exp=%h", i, n, obs[i], exp); end
      end
      n_cmp++; if (consumed !== nclamp) begin n_bad++; $display("FAIL rnd_consumed n=%0d got=%0d exp=%0d", n, consumed, nclamp); end
      n_cmp++; if (done_cnt !== 1 || last_bad !== 0) begin n_bad++; $display("FAIL rnd_done n=%0d got=%0d/%0d exp=1/0", n, done_cnt, last_bad); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_n();
    test_full();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/zero_pad_block.md
Name: zero_pad_block

Overview:
Input-side framing block for the fast correlator. It accepts one frame of N valid samples on an AXI-Stream slave and forwards them unchanged. It then appends NFFT-N zero samples so the FFT core always receives exactly NFFT beats. It is the counterpart of the output truncation block: that block discards the padded tail after the IFFT, and this block creates the padded tail before the FFT.

Parameters:
NFFT, 256, FFT length; total output beats per frame; power of two, 2..8192.

Ports:
aclk  input  1  clock
aresetn  input  1  synchronous active-low reset
N  input  13  number of real samples in the frame; sampled on start
start  input  1  single-cycle frame request; honoured only in IDLE
busy  output  1  high while a frame is in progress (state != IDLE)
done  output  1  single-cycle pulse on the final output beat of a frame
out_last  output  1  marks the final output beat (beat NFFT-1); valid while outdata.tvalid is high
indata  AXIS_intf.Slave  interface-defined  input sample stream (tdata, tvalid, tready)
outdata  AXIS_intf.Master  interface-defined  padded stream to the FFT (tdata, tvalid, tready)

Behaviour:
- Clocking and reset: single clock aclk. Reset is synchronous and active-low on aresetn, sampled at posedge aclk.
- Reset values: state=IDLE, counter=0, n_reg=0. Resulting outputs: outdata.tvalid=0, indata.tready=0, done=0, busy=0, out_last=0.
- Reset mid-frame: abort immediately, with no flush and no done pulse.
- Registers:
  - state is one of {IDLE, PASS, PAD}.
  - counter is 14 bits and counts accepted output beats (outdata.tvalid & outdata.tready).
  - n_reg is 14 bits.
- On start in IDLE:
  - n_reg <= min(N, NFFT); any N > NFFT is clamped to NFFT.
  - counter <= 0.
  - Next state is PASS if the clamped N > 0, else PAD.
- start outside IDLE is ignored. Changes on N outside the start cycle are ignored.
- IDLE:
  - indata.tready=0, outdata.tvalid=0, outdata.tdata=0.
- PASS (zero-latency combinational pass-through):
  - outdata.tvalid = indata.tvalid.
  - indata.tready = outdata.tready.
  - outdata.tdata = indata.tdata.
  - On an accepted beat with counter == n_reg-1:
    - if n_reg == NFFT: go to IDLE (this is the final beat);
    - otherwise go to PAD.
- PAD:
  - indata.tready=0, so upstream samples beyond N are held, not consumed.
  - outdata.tvalid=1, outdata.tdata=0.
  - On an accepted beat with counter == NFFT-1: go to IDLE.
- Counter: increments on every accepted output beat in PASS and PAD. It never exceeds NFFT-1 within a frame and is cleared in IDLE.
- out_last = (state != IDLE) & (counter == NFFT-1).
- done = outdata.tvalid & outdata.tready & out_last. It is combinational and coincides with the final accepted beat. Exactly one pulse per frame.
- Backpressure:
  - outdata.tready low holds counter and state.
  - In PAD, tvalid stays high and tdata stays 0 while stalled.
  - In PASS, tvalid and tdata follow upstream; AXIS stability is inherited from the source.
- Back-to-back frames: the cycle of the final beat returns the block to IDLE, so a start in that same cycle is ignored. The minimum gap is one IDLE cycle, and start is accepted in the first IDLE cycle.
- Output beats per frame: always exactly NFFT. The first min(N, NFFT) beats are input samples; the rest are zeros.
- Width: N is zero-extended to 14 bits before comparison, so NFFT=8192 is handled without overflow.

Test Plan:
1. NFFT=16, N=5, inputs 1..5, tready always 1 -> outputs 1,2,3,4,5 then 11 zeros. done and out_last high on beat 16 only. 5 inputs consumed. busy falls the cycle after done.
2. NFFT=16, N=0 -> 16 zero beats, indata.tready never asserted, single done on beat 16.
3. NFFT=16, N=16, and separately N=20 -> 16 input beats passed, no zeros inserted, 17th input sample not consumed, done on beat 16.
4. NFFT=16, N=8, random outdata.tready and indata.tvalid gaps -> data order preserved, zero beats hold tdata=0 under stall, counter frozen while tready=0, exactly 16 accepted beats.
5. start pulsed mid-frame, and again in the done cycle -> both ignored; start on the next IDLE cycle begins a new frame with a freshly sampled N.
6. aresetn low during PAD at beat 10 -> next cycle outdata.tvalid=0, busy=0, no done pulse. A new start after reset produces a full, correct 16-beat frame.
